// File: rtl/spike_mon_pkg.sv
// Shared state encoding, default widths and saturating-increment helper for the spike rate monitor.
// Latency: none (declarations only). Optional edge counting is selected by SPIKE_MON_EDGE_EN.
// Backpressure: none.
package spike_mon_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 16;

  // Callers zero-extend their counter to 32 bits and pass their own ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val,
                                          input logic        inc);
    sat_inc = (inc && (val < max_val)) ? val + 32'd1 : val;
  endfunction

endpackage

// File: rtl/spike_chan_counter.sv
// One channel: saturating spike accumulator, sticky overflow, and snapshot taken on window close.
// Latency: snapshot/overflow update on the close edge. SPIKE_MON_EDGE_EN counts rising edges only.
// Backpressure: none; a spike is sampled every cycle clear is low.
module spike_chan_counter
  import spike_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             close,
  input  logic             spike,
  output logic [CNT_W-1:0] snapshot,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_nxt;
  logic             ovf_acc;
  logic             hit;
  logic             ovf_hit;

`ifdef SPIKE_MON_EDGE_EN
  logic spike_prev;

  // Tracks the raw level across window boundaries so a held spike never recounts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_prev <= 1'b0;
    end else if (clear) begin
      spike_prev <= 1'b0;
    end else begin
      spike_prev <= spike;
    end
  end

  assign hit = spike & ~spike_prev;
`else
  assign hit = spike;
`endif

  assign acc_nxt = CNT_W'(sat_inc(32'(acc), 32'(CNT_MAX), hit));
  assign ovf_hit = hit && (acc == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      ovf_acc  <= 1'b0;
      snapshot <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      acc     <= '0;
      ovf_acc <= 1'b0;
    end else if (close) begin
      snapshot <= acc_nxt;
      overflow <= ovf_acc | ovf_hit;
      acc      <= '0;
      ovf_acc  <= 1'b0;
    end else begin
      acc     <= acc_nxt;
      ovf_acc <= ovf_acc | ovf_hit;
    end
  end

endmodule

// File: rtl/spike_rate_monitor.sv
// Per-channel spike counts over back-to-back programmable windows; one snapshot muxed to count_out.
// Latency: snapshot, window_done, overflow visible the cycle after close. Macro: SPIKE_MON_EDGE_EN.
// Backpressure: none; inputs sampled every cycle in COUNT, count_out combinational on ch_sel.
module spike_rate_monitor
  import spike_mon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WIN_W  = DEF_WIN_W,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] spikes,
  input  logic [WIN_W-1:0]  win_len,
  input  logic [SEL_W-1:0]  ch_sel,
  output logic [CNT_W-1:0]  count_out,
  output logic              count_valid,
  output logic              window_done,
  output logic [NUM_CH-1:0] overflow
);

  state_t           state;
  logic [WIN_W-1:0] wcnt;
  logic [WIN_W-1:0] wcnt_load;
  logic             clear;
  logic             close;
  logic [CNT_W-1:0] snap [NUM_CH];

  // A zero length behaves as a one-sample window.
  assign wcnt_load = (win_len == '0) ? '0 : win_len - WIN_W'(1);
  assign clear     = (state == ST_IDLE);
  assign close     = (state == ST_COUNT) && (wcnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      window_done <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      window_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_COUNT;
            wcnt  <= wcnt_load;
          end
        end
        ST_COUNT: begin
          if (close) begin
            window_done <= 1'b1;
            count_valid <= 1'b1;
            wcnt        <= wcnt_load;
          end else begin
            wcnt <= wcnt - WIN_W'(1);
          end
          // A close on the same edge still snapshots; validity restarts on IDLE entry.
          if (!enable) begin
            state       <= ST_IDLE;
            count_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    spike_chan_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .close    (close),
      .spike    (spikes[i]),
      .snapshot (snap[i]),
      .overflow (overflow[i])
    );
  end

  always_comb begin
    count_out = '0;
    if (32'(ch_sel) < NUM_CH) begin
      count_out = snap[ch_sel];
    end
  end

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed bench for spike_rate_monitor with a window/rate model checked every cycle.
module tb_spike_rate_monitor;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int WIN_W  = 16;
  localparam int SEL_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef SPIKE_MON_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [NUM_CH-1:0] spikes;
  logic [WIN_W-1:0]  win_len;
  logic [SEL_W-1:0]  ch_sel;
  logic [CNT_W-1:0]  count_out;
  logic              count_valid;
  logic              window_done;
  logic [NUM_CH-1:0] overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spike_rate_monitor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SEL_W(SEL_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .spikes      (spikes),
    .win_len     (win_len),
    .ch_sel      (ch_sel),
    .count_out   (count_out),
    .count_valid (count_valid),
    .window_done (window_done),
    .overflow    (overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: windows as sample counts, rates as plain integers
  bit m_run, m_done, m_valid;
  int m_len, m_pos;
  int m_cnt  [NUM_CH];
  bit m_prev [NUM_CH];
  int m_snap [NUM_CH];
  bit m_ovf  [NUM_CH];

  function automatic int eff_len(input logic [WIN_W-1:0] w);
    return (w == '0) ? 1 : int'(w);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_valid = 0; m_len = 0; m_pos = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt[i] = 0; m_prev[i] = 0; m_snap[i] = 0; m_ovf[i] = 0;
      end
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (enable) begin
          m_run = 1; m_pos = 0; m_len = eff_len(win_len);
          for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0; m_prev[i] = 0;
          end
        end
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (EDGE) begin
            if (spikes[i] && !m_prev[i]) m_cnt[i]++;
          end else begin
            if (spikes[i]) m_cnt[i]++;
          end
          m_prev[i] = spikes[i];
        end
        m_pos++;
        if (m_pos == m_len) begin
          for (int i = 0; i < NUM_CH; i++) begin
            m_snap[i] = (m_cnt[i] > CMAX) ? CMAX : m_cnt[i];
            m_ovf[i]  = (m_cnt[i] > CMAX);
            m_cnt[i]  = 0;
          end
          m_pos = 0; m_len = eff_len(win_len); m_done = 1; m_valid = 1;
        end
        if (!enable) begin
          m_run = 0; m_valid = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare, well clear of both clock edges
  always begin
    logic [NUM_CH-1:0] ov;
    @(negedge clk);
    #4;
    for (int i = 0; i < NUM_CH; i++) ov[i] = m_ovf[i];
    chk("cmp_count_out",   int'(count_out),   m_snap[ch_sel]);
    chk("cmp_count_valid", int'(count_valid), int'(m_valid));
    chk("cmp_window_done", int'(window_done), int'(m_done));
    chk("cmp_overflow",    int'(overflow),    int'(ov));
  end

  // ---------------- directed stimulus helpers
  task automatic sel_chk(input string name, input int ch, input int exp);
    ch_sel = SEL_W'(ch);
    #1;
    chk(name, int'(count_out), exp);
  endtask

  task automatic wait_done(input int max_cyc, output int k);
    k = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (window_done) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    enable = 1'b0;
    spikes = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int k;
    int pulses;
    rst_n = 1'b0; enable = 1'b0; spikes = '0; win_len = '0; ch_sel = '0;
    repeat (2) @(negedge clk);
    chk("rst_count_out", int'(count_out), 0);
    chk("rst_valid",     int'(count_valid), 0);
    chk("rst_done",      int'(window_done), 0);
    chk("rst_ovf",       int'(overflow), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic rate: ch0 three samples, ch1 every sample, 10-cycle window.
    win_len = 16'd10; enable = 1'b1;
    k = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (window_done) begin
        k = i;
        spikes = '0;
        break;
      end
      ch_sel = SEL_W'(i);
      spikes = 4'b0010 | ((i <= 3) ? 4'b0001 : 4'b0000);
    end
    chk("basic_latency", k, 11);
    sel_chk("basic_ch0", 0, 3);
    sel_chk("basic_ch1", 1, 10);
    sel_chk("basic_ch2", 2, 0);
    chk("basic_ovf",   int'(overflow), 0);
    chk("basic_valid", int'(count_valid), 1);
    go_idle();

    // Saturation, then a quiet window clears the count and the flag.
    win_len = 16'd300; enable = 1'b1; spikes = 4'b0100;
    wait_done(400, k);
    chk("sat_latency", k, 301);
    sel_chk("sat_ch2", 2, 255);
    sel_chk("sat_ch0", 0, 0);
    chk("sat_ovf", int'(overflow), 4);
    spikes = '0;
    wait_done(400, k);
    chk("sat2_latency", k, 300);
    sel_chk("sat2_ch2", 2, 0);
    chk("sat2_ovf", int'(overflow), 0);
    go_idle();

    // Back-to-back 4-cycle windows; win_len changed mid-window takes effect at the following reload.
    win_len = 16'd4; enable = 1'b1; ch_sel = 2'd3; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("b2b_done", int'(window_done), int'(i == 5 || i == 9 || i == 13 || i == 20));
      if (window_done) pulses++;
      if (i == 5) chk("b2b_win1_ch3", int'(count_out), 1);
      if (i == 9) chk("b2b_win2_ch3", int'(count_out), 0);
      if (i == 10) win_len = 16'd7;
      spikes = (i == 4) ? 4'b1000 : 4'b0000;
    end
    chk("b2b_pulses", pulses, 4);
    go_idle();

    // Abort on the fifth sample of the second window.
    win_len = 16'd10; enable = 1'b1; spikes = 4'b0010; ch_sel = 2'd1;
    wait_done(30, k);
    chk("abort_first_latency", k, 11);
    spikes = 4'b0001;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (window_done) pulses++;
    end
    chk("abort_pulses", pulses, 0);
    sel_chk("abort_ch1_kept", 1, 10);
    sel_chk("abort_ch0_kept", 0, 0);
    chk("abort_valid", int'(count_valid), 0);

    // win_len = 0 acts as a one-sample window.
    @(negedge clk);
    win_len = '0; enable = 1'b1; spikes = 4'b0001; ch_sel = 2'd0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("wl0_done", int'(window_done), int'(i >= 2));
      if (i == 3) chk("wl0_ch0", int'(count_out), EDGE ? 0 : 1);
    end
    go_idle();

    // Five-sample pulse: one edge, or five levels.
    win_len = 16'd10; enable = 1'b1; ch_sel = 2'd0;
    k = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (window_done) begin
        k = i;
        break;
      end
      spikes = (i <= 5) ? 4'b0001 : 4'b0000;
    end
    chk("edge_latency", k, 11);
    sel_chk("edge_ch0", 0, EDGE ? 1 : 5);
    go_idle();

    // Async reset in the middle of a window with spikes active.
    win_len = 16'd6; enable = 1'b1; spikes = 4'b1111; ch_sel = 2'd1;
    wait_done(20, k);
    chk("rst2_latency", k, 7);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count_out", int'(count_out), 0);
    chk("arst_valid",     int'(count_valid), 0);
    chk("arst_done",      int'(window_done), 0);
    chk("arst_ovf",       int'(overflow), 0);
    @(negedge clk);
    enable = 1'b0; spikes = '0; rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ch_sel = SEL_W'(i);
      #1;
      if (window_done) pulses++;
      chk("post_rst_count_out", int'(count_out), 0);
    end
    chk("post_rst_pulses", pulses, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
